// File: rtl/alu_wb_regfile.sv
// 32x32 register file for ALU write-back with two combinational read ports,
// optional write-to-read forwarding and an optional ALU status-flag register.
module alu_wb_regfile #(
  parameter bit BYPASS  = 1'b1,
  parameter bit FLAG_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [4:0]  raddr1,
  input  logic [4:0]  raddr2,
  output logic [31:0] rdata1,
  output logic [31:0] rdata2,
  input  logic        flag_we,
  input  logic [3:0]  flags_in,
  output logic [3:0]  flags_q
);

  localparam int unsigned DW   = 32;
  localparam int unsigned AW   = 5;
  localparam int unsigned NREG = 32;
  localparam int unsigned FW   = 4;

  logic [DW-1:0] regs [NREG];
  logic          wr_en;

  // Index 0 is hardwired, so it is never a legal write or forwarding target.
  assign wr_en = we && (waddr != AW'(0));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(NREG); i++) begin
        regs[i] <= '0;
      end
    end else if (wr_en) begin
      regs[waddr] <= wdata;
    end
  end

  // Reset gates the read ports directly so they read 0 without a clock edge.
  always_comb begin
    rdata1 = '0;
    if (!rst && (raddr1 != AW'(0))) begin
      if (BYPASS && wr_en && (waddr == raddr1)) begin
        rdata1 = wdata;
      end else begin
        rdata1 = regs[raddr1];
      end
    end
  end

  always_comb begin
    rdata2 = '0;
    if (!rst && (raddr2 != AW'(0))) begin
      if (BYPASS && wr_en && (waddr == raddr2)) begin
        rdata2 = wdata;
      end else begin
        rdata2 = regs[raddr2];
      end
    end
  end

  generate
    if (FLAG_EN) begin : g_flags
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          flags_q <= '0;
        end else if (flag_we) begin
          flags_q <= flags_in;
        end
      end
    end else begin : g_no_flags
      assign flags_q = FW'(0);
    end
  endgenerate

endmodule

// File: tb/tb_alu_wb_regfile.sv
// Directed and random checks of alu_wb_regfile, run on a forwarding and a
// non-forwarding instance driven by the same stimulus.
module tb_alu_wb_regfile;

  logic        clk;
  logic        rst;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [4:0]  raddr1;
  logic [4:0]  raddr2;
  logic        flag_we;
  logic [3:0]  flags_in;
  logic [31:0] rdata1_b, rdata2_b, rdata1_n, rdata2_n;
  logic [3:0]  flags_b, flags_n;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] mdl [32];
  logic [3:0]  mflags;

  alu_wb_regfile #(.BYPASS(1'b1), .FLAG_EN(1'b1)) dut_b (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr1(raddr1), .raddr2(raddr2), .rdata1(rdata1_b), .rdata2(rdata2_b),
    .flag_we(flag_we), .flags_in(flags_in), .flags_q(flags_b)
  );

  alu_wb_regfile #(.BYPASS(1'b0), .FLAG_EN(1'b1)) dut_n (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr1(raddr1), .raddr2(raddr2), .rdata1(rdata1_n), .rdata2(rdata2_n),
    .flag_we(flag_we), .flags_in(flags_in), .flags_q(flags_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference read: reset forces 0, index 0 is 0, forwarding only when enabled.
  function automatic logic [31:0] exp_rd(input bit byp, input logic [4:0] ra);
    if (rst || ra == 5'd0) return 32'h0;
    if (byp && we && waddr != 5'd0 && waddr == ra) return wdata;
    return mdl[ra];
  endfunction

  task automatic check_reads(input string tag);
    check({tag, "_b_rd1"}, rdata1_b, exp_rd(1'b1, raddr1));
    check({tag, "_b_rd2"}, rdata2_b, exp_rd(1'b1, raddr2));
    check({tag, "_n_rd1"}, rdata1_n, exp_rd(1'b0, raddr1));
    check({tag, "_n_rd2"}, rdata2_n, exp_rd(1'b0, raddr2));
  endtask

  // One rising edge, with the reference model updated from the inputs seen there.
  task automatic step();
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
      mflags = 4'h0;
    end else begin
      if (we && waddr != 5'd0) mdl[waddr] = wdata;
      if (flag_we) mflags = flags_in;
    end
    #1;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
    mflags   = 4'h0;
    rst      = 1'b1;
    we       = 1'b0;
    waddr    = 5'd0;
    wdata    = 32'h0;
    raddr1   = 5'd0;
    raddr2   = 5'd0;
    flag_we  = 1'b0;
    flags_in = 4'h0;
    #2;
    check("rst_rd1", rdata1_b, 32'h0);
    check("rst_flags", 32'(flags_b), 32'h0);

    // Write attempted during reset: neither forwarded nor stored.
    we = 1'b1; waddr = 5'd3; wdata = 32'hCAFEF00D; raddr1 = 5'd3; raddr2 = 5'd3;
    #1;
    check("rst_nofwd_b", rdata1_b, 32'h0);
    step();
    rst = 1'b0; we = 1'b0;
    #1;
    check("rst_nowrite_b", rdata1_b, 32'h0);
    check("rst_nowrite_n", rdata2_n, 32'h0);

    // Basic write then read.
    we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF;
    step();
    we = 1'b0; raddr1 = 5'd5; raddr2 = 5'd6;
    #1;
    check("wr5_b_rd1", rdata1_b, 32'hDEADBEEF);
    check("wr5_n_rd1", rdata1_n, 32'hDEADBEEF);
    check("rd6_b_rd2", rdata2_b, 32'h0);

    // Index 0 hardwired, never forwarded.
    we = 1'b1; waddr = 5'd0; wdata = 32'hFFFFFFFF; raddr1 = 5'd0;
    #1;
    check("r0_same_b", rdata1_b, 32'h0);
    check("r0_same_n", rdata1_n, 32'h0);
    step();
    we = 1'b0;
    #1;
    check("r0_next_b", rdata1_b, 32'h0);

    // Same-cycle forwarding vs registered-only.
    we = 1'b1; waddr = 5'd9; wdata = 32'h12345678; raddr1 = 5'd9; raddr2 = 5'd9;
    #1;
    check("byp_b_rd1", rdata1_b, 32'h12345678);
    check("byp_b_rd2", rdata2_b, 32'h12345678);
    check("nobyp_n_rd1", rdata1_n, 32'h0);
    check("nobyp_n_rd2", rdata2_n, 32'h0);
    step();
    we = 1'b0;
    #1;
    check("wr9_n_rd1", rdata1_n, 32'h12345678);
    check("wr9_n_rd2", rdata2_n, 32'h12345678);

    // Flags capture and hold.
    flag_we = 1'b1; flags_in = 4'b1010;
    step();
    check("flag_cap", 32'(flags_b), 32'h0000000A);
    flag_we = 1'b0; flags_in = 4'b0101;
    step();
    check("flag_hold", 32'(flags_b), 32'h0000000A);

    // Register write and flag capture in the same cycle.
    we = 1'b1; waddr = 5'd7; wdata = 32'hA5A5A5A5; flag_we = 1'b1; flags_in = 4'b0011;
    step();
    we = 1'b0; flag_we = 1'b0; raddr1 = 5'd7;
    #1;
    check("both_rd7", rdata1_n, 32'hA5A5A5A5);
    check("both_flags", 32'(flags_n), 32'h00000003);

    // Fill 1..31 with their own index.
    for (int i = 1; i < 32; i++) begin
      we = 1'b1; waddr = 5'(i); wdata = 32'(i);
      step();
    end
    we = 1'b0; raddr1 = 5'd31; raddr2 = 5'd4;
    #1;
    check("fill_rd31", rdata1_n, 32'd31);
    check("fill_rd4", rdata2_b, 32'd4);

    // Async reset between edges, with a write pending.
    #2;
    rst = 1'b1; we = 1'b1; waddr = 5'd4; wdata = 32'hFFFF0000;
    #1;
    check("arst_b_rd1", rdata1_b, 32'h0);
    check("arst_b_rd2", rdata2_b, 32'h0);
    check("arst_n_rd1", rdata1_n, 32'h0);
    check("arst_flags", 32'(flags_b), 32'h0);
    step();
    rst = 1'b0; we = 1'b0;
    #1;
    check("post_rst_rd31", rdata1_n, 32'h0);
    check("post_rst_rd4", rdata2_n, 32'h0);
    check("post_rst_flags", 32'(flags_n), 32'h0);

    // First edge after reset release writes.
    we = 1'b1; waddr = 5'd2; wdata = 32'h00C0FFEE;
    step();
    we = 1'b0; raddr1 = 5'd2;
    #1;
    check("first_wr", rdata1_n, 32'h00C0FFEE);

    // Random traffic against the reference model.
    for (int c = 0; c < 10000; c++) begin
      we       = 1'($urandom_range(0, 1));
      waddr    = 5'($urandom_range(0, 31));
      wdata    = $urandom;
      flag_we  = 1'($urandom_range(0, 1));
      flags_in = 4'($urandom_range(0, 15));
      raddr1   = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom_range(0, 31));
      raddr2   = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom_range(0, 31));
      #1;
      check_reads("rnd");
      step();
      check("rnd_flags_b", 32'(flags_b), 32'(mflags));
      check("rnd_flags_n", 32'(flags_n), 32'(mflags));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
